// File: rtl/wildcat_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-entry
// valid/ready output buffer with framing-error and overrun pulses.
module wildcat_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic rx_s;
    logic sample;
    logic byte_done;
    logic xfer;

    assign rx_s   = sync2_q;
    assign sample = (cnt_q == '0);
    assign xfer   = rx_valid_q & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (sample) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (sample && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (sample) state_d = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync1_d     = rxd;
        sync2_d     = sync1_q;
        cnt_d       = sample ? cnt_q : cnt_q - CNT_ONE;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: if (!rx_s) cnt_d = CNT_HALF;
            S_START: begin
                if (sample && !rx_s) begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = CNT_FULL;
                end
            end
            S_STOP: begin
                if (sample) begin
                    byte_done   = rx_s;
                    frame_err_d = ~rx_s;
                end
            end
            default: ;
        endcase

        // A completed byte may replace buffered data only if that data leaves this cycle.
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~xfer;
        overrun_d  = 1'b0;
        if (byte_done) begin
            if (!rx_valid_q || xfer) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_wildcat_uart_rx.sv
// Self-checking bench for wildcat_uart_rx: directed scenarios plus randomized
// frames scored against a queue-based model of delivered bytes.
module tb_wildcat_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    int unsigned rise_cyc = 0;
    int unsigned ov_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int stab_err = 0;
    logic vld_prev = 1'b0;
    logic xfer_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] acc_q[$];
    bit rnd_done = 1'b0;

    wildcat_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: handshakes, pulses, data stability.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
        if (rx_valid === 1'b1 && vld_prev !== 1'b1) rise_cyc <= cyc;
        if (vld_prev === 1'b1 && xfer_prev !== 1'b1 && rx_valid === 1'b1 && rx_data !== data_prev)
            stab_err <= stab_err + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
        vld_prev  <= rx_valid;
        xfer_prev <= rx_valid & rx_ready;
        data_prev <= rx_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        last_fall = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
    endtask

    task automatic accept_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rxd = 1'($urandom_range(0, 1));
            tick(1);
            checks++;
            if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b data=%h fe=%b ov=%b, required 0 00 0 0",
                         rx_valid, rx_data, frame_err, overrun);
            end
        end
        rxd = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(100);
        checks++;
        if (rx_valid !== 1'b0 || acc_q.size() != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b accepted=%0d fe=%0d ov=%0d, required 0 0 0 0",
                     rx_valid, acc_q.size(), fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_single();
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        rxd = 1'b1;
        checks++;
        if (rise_cyc - last_fall != 79) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required 79", rise_cyc - last_fall);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: valid=%b data=%h, required 1 a5", rx_valid, rx_data);
        end
        accept_one();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: valid=%b, required 0", rx_valid);
        end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_accept: accepted=%0d, required one byte a5", acc_q.size());
        end
        acc_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int ov0;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
        ov0 = ov_cnt;
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        rxd = 1'b1;
        tick(4);
        rx_ready = 1'b0;
        checks++;
        if (acc_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes, required 3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h, required %h", i, acc_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (ov_cnt != ov0) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d pulses, required 0", ov_cnt - ov0);
        end
        acc_q.delete();
    endtask

    task automatic test_overrun();
        int ov0;
        int unsigned f2;
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        f2 = last_fall;
        rxd = 1'b1;
        tick(4);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_keep: valid=%b data=%h, required 1 11", rx_valid, rx_data);
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_cnt - ov0);
        end
        checks++;
        if (ov_cyc - f2 < 78 || ov_cyc - f2 > 79) begin
            errors++;
            $display("FAIL overrun_time: got %0d cycles after start, required 78..79", ov_cyc - f2);
        end
        accept_one();
        tick(20);
        checks++;
        if (rx_valid !== 1'b0 || acc_q.size() != 1 || acc_q[0] !== 8'h11) begin
            errors++;
            $display("FAIL overrun_accept: valid=%b accepted=%0d, required 0 and one byte 11",
                     rx_valid, acc_q.size());
        end
        acc_q.delete();
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b0);
        tick(40);
        checks++;
        if (fe_cnt - fe0 != 1 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_pulse: pulses=%0d valid=%b, required 1 0", fe_cnt - fe0, rx_valid);
        end
        rxd = 1'b1;
        tick(10);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL frame_err_break: pulses=%0d, required 1", fe_cnt - fe0);
        end
        send_frame(8'h5A, 1'b1);
        rxd = 1'b1;
        tick(2);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL frame_err_recover: valid=%b data=%h, required 1 5a", rx_valid, rx_data);
        end
        accept_one();
        acc_q.delete();
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(40);
        checks++;
        if (rx_valid !== 1'b0 || acc_q.size() != 0 || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL glitch: valid=%b accepted=%0d fe=%0d, required 0 0 1",
                     rx_valid, acc_q.size(), fe_cnt - fe0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hC3;
        rx_ready = 1'b0;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (rx_valid !== 1'b0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_abandon: valid=%b accepted=%0d, required 0 0", rx_valid, acc_q.size());
        end
        send_frame(8'h7E, 1'b1);
        rxd = 1'b1;
        tick(3);
        accept_one();
        tick(20);
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'h7E || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: accepted=%0d valid=%b, required one byte 7e and valid 0",
                     acc_q.size(), rx_valid);
        end
        acc_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int nbad;
        int fe0;
        int ov0;
        nbad = 0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] b;
                    logic stop;
                    b = 8'($urandom);
                    stop = ($urandom_range(0, 3) != 0);
                    send_frame(b, stop);
                    rxd = 1'b1;
                    if (stop) begin
                        exp_q.push_back(b);
                        tick($urandom_range(0, 5));
                    end else begin
                        nbad++;
                        tick(3 + $urandom_range(0, 4));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rx_ready = 1'b1;
        tick(4);
        rx_ready = 1'b0;
        checks++;
        if (acc_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d bytes, required %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (acc_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_byte%0d: got %h, required %h", i, acc_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (fe_cnt - fe0 != nbad || ov_cnt != ov0) begin
            errors++;
            $display("FAIL random_flags: fe=%0d ov=%0d, required %0d 0", fe_cnt - fe0, ov_cnt - ov0, nbad);
        end
        acc_q.delete();
    endtask

    task automatic test_stability();
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL data_stable: %0d changes while valid held, required 0", stab_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        test_random();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
